// File: rtl/two_parallel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : two_parallel_serializer
// Brief    : Shifts and narrows FIR sample pairs into a FIFO, then emits them
//            serially even-then-odd. Optional saturation via SERIALIZER_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module two_parallel_serializer #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_d1,
    input  logic [IN_W-1:0]  in_d2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef SERIALIZER_SAT_EN
    ,
    output logic             sat_seen
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] c_FULL = (PW+1)'(DEPTH);

`ifdef SERIALIZER_SAT_EN
    localparam logic signed [IN_W-1:0] c_MAX_W = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] c_MIN_W = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] x);
        logic signed [IN_W-1:0] v;
        v = $signed(x) >>> SHIFT;
        if (v > c_MAX_W)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (v < c_MIN_W)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
    endfunction

    function automatic logic clamps(input logic [IN_W-1:0] x);
        logic signed [IN_W-1:0] v;
        v = $signed(x) >>> SHIFT;
        return (v > c_MAX_W) || (v < c_MIN_W);
    endfunction
`else
    function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] x);
        return OUT_W'($signed(x) >>> SHIFT);
    endfunction
`endif

    logic [OUT_W-1:0] r_mem1 [DEPTH];
    logic [OUT_W-1:0] r_mem2 [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             r_phase;

    logic             w_push;
    logic             w_pop;
    logic             w_free;
    logic [OUT_W-1:0] w_n1;
    logic [OUT_W-1:0] w_n2;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_free    = w_pop && r_phase;
    assign w_n1      = narrow(in_d1);
    assign w_n2      = narrow(in_d2);

    // Plain register mux: no conversion logic on the output path.
    assign out_data  = r_phase ? r_mem2[r_rptr] : r_mem1[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem1[i] <= '0;
                r_mem2[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem1[r_wptr] <= w_n1;
                r_mem2[r_wptr] <= w_n2;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop)
                r_phase <= ~r_phase;
            if (w_free)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_free})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SERIALIZER_SAT_EN
    logic r_sat_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_seen <= 1'b0;
        else if (w_push && (clamps(in_d1) || clamps(in_d2)))
            r_sat_seen <= 1'b1;
    end

    assign sat_seen = r_sat_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_two_parallel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_two_parallel_serializer
// Brief    : Directed self-checking bench; second instance uses SHIFT = 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_two_parallel_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_d1 = '0;
    logic [63:0] in_d2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [63:0] s_in_d1 = '0;
    logic [63:0] s_in_d2 = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_out_data;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SERIALIZER_SAT_EN
    logic sat_seen;
    logic s_sat_seen;
`endif

    always #5 clk = ~clk;

    two_parallel_serializer #(.IN_W(64), .OUT_W(16), .SHIFT(0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_d1(in_d1), .in_d2(in_d2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SERIALIZER_SAT_EN
        , .sat_seen(sat_seen)
`endif
    );

    two_parallel_serializer #(.IN_W(64), .OUT_W(16), .SHIFT(4), .DEPTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_d1(s_in_d1), .in_d2(s_in_d2),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
`ifdef SERIALIZER_SAT_EN
        , .sat_seen(s_sat_seen)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_d1 = 64'd5; in_d2 = -64'sd7; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd5) begin n_err++; $display("FAIL reset_first_d1 got v=%b d=%h want v=1 d=0005", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'hFFF9) begin n_err++; $display("FAIL reset_first_d2 got v=%b d=%h want v=1 d=fff9", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_d1 = 64'(2*k+1); in_d2 = 64'(2*k+2);
            step();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(2*k+1)) begin n_err++; $display("FAIL stream_d1[%0d] got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, 2*k+1); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(2*k+2)) begin n_err++; $display("FAIL stream_d2[%0d] got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, 2*k+2); end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_full_wrap;
        logic [15:0] exp_q [10];
        int got;
        for (int i = 0; i < 5; i++) begin
            exp_q[2*i]   = 16'(100 + i);
            exp_q[2*i+1] = 16'(200 + i);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_d1 = 64'(100 + i); in_d2 = 64'(200 + i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_accept[%0d] got in_ready=%b want 1", i, in_ready); end
            step();
        end
        in_d1 = 64'd104; in_d2 = 64'd204;
        step(); step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd100) begin n_err++; $display("FAIL full_head got v=%b d=%0d want v=1 d=100", out_valid, out_data); end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            logic pushing;
            pushing = in_valid && in_ready;
            if (out_valid) begin
                n_cmp++; if (out_data !== exp_q[got]) begin n_err++; $display("FAIL wrap_seq[%0d] got %0d want %0d", got, out_data, exp_q[got]); end
                got++;
            end
            step();
            if (pushing) in_valid = 1'b0;
        end
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL wrap_timeout got %0d samples want 10", got); end
        n_cmp++; if (out_valid !== 1'b0 || in_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drain got v=%b pending=%b want 0 0", out_valid, in_valid); end
    endtask

    task automatic test_stall;
        out_ready = 1'b1;
        in_valid = 1'b1; in_d1 = 64'd10; in_d2 = 64'd20;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 16'd10) begin n_err++; $display("FAIL stall_d1 got %0d want 10", out_data); end
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd20) begin n_err++; $display("FAIL stall_hold[%0d] got v=%b d=%0d want v=1 d=20", i, out_valid, out_data); end
            step();
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got v=%b want 0", out_valid); end
    endtask

    task automatic test_narrow;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
`ifdef SERIALIZER_SAT_EN
        exp_hi = 16'h7FFF; exp_lo = 16'h8000;
        n_cmp++; if (s_sat_seen !== 1'b0) begin n_err++; $display("FAIL sat_initial got %b want 0", s_sat_seen); end
`else
        exp_hi = 16'h0000; exp_lo = 16'h0000;
`endif
        s_out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_d1 = 64'h1230; s_in_d2 = 64'd1 << 40;
        step();
        s_in_valid = 1'b0;
        n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h0123) begin n_err++; $display("FAIL narrow_shift got v=%b d=%h want v=1 d=0123", s_out_valid, s_out_data); end
`ifdef SERIALIZER_SAT_EN
        n_cmp++; if (s_sat_seen !== 1'b1) begin n_err++; $display("FAIL sat_set got %b want 1", s_sat_seen); end
`endif
        step();
        n_cmp++; if (s_out_data !== exp_hi) begin n_err++; $display("FAIL narrow_pos got %h want %h", s_out_data, exp_hi); end
        s_in_valid = 1'b1; s_in_d1 = -(64'd1 << 40); s_in_d2 = -64'sd16;
        step();
        s_in_valid = 1'b0;
        n_cmp++; if (s_out_data !== exp_lo) begin n_err++; $display("FAIL narrow_neg got %h want %h", s_out_data, exp_lo); end
        step();
        n_cmp++; if (s_out_data !== 16'hFFFF) begin n_err++; $display("FAIL narrow_minus1 got %h want ffff", s_out_data); end
`ifdef SERIALIZER_SAT_EN
        step();
        n_cmp++; if (s_sat_seen !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b want 1", s_sat_seen); end
`endif
    endtask

    task automatic test_reset_mid_pair;
        out_ready = 1'b1;
        in_valid = 1'b1; in_d1 = 64'd7; in_d2 = 64'd8;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 16'd7) begin n_err++; $display("FAIL midrst_d1 got %0d want 7", out_data); end
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin n_err++; $display("FAIL midrst_state got v=%b r=%b d=%h want 0 1 0000", out_valid, in_ready, out_data); end
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_d1 = 64'd9; in_d2 = 64'd11;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd9) begin n_err++; $display("FAIL midrst_next_d1 got v=%b d=%0d want v=1 d=9", out_valid, out_data); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'd11) begin n_err++; $display("FAIL midrst_next_d2 got v=%b d=%0d want v=1 d=11", out_valid, out_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_full_wrap();
        test_stall();
        test_narrow();
        test_reset_mid_pair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
